// File: rtl/cnn_seq_pkg.sv
// Shared types and helpers for the CNN layer sequencer.
package cnn_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    FINISH,
    ERROR
  } seq_state_e;

  // Width of a stage index port: one spare bit so N_STAGES itself is representable.
  function automatic int stage_idx_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/cnn_layer_sequencer_watchdog.sv
// seq_watchdog: per-stage busy-cycle counter; flags when a stage has waited TIMEOUT cycles.
module seq_watchdog #(
  parameter int TIMEOUT = 200000,
  parameter int CNT_W   = $clog2(TIMEOUT) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Holds at LIMIT so a long-lived enable never wraps back to a quiet value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && count != LIMIT) begin
      count <= count + 1'b1;
    end
  end

  assign timeout = enable && (count == LIMIT);

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Frame scheduler: launches stages 0..N_STAGES-1 in order with a per-stage watchdog.
// Define CNN_SEQ_PERF_EN to build the per-stage cycle counters behind perf_cycles.
module cnn_layer_sequencer
  import cnn_seq_pkg::*;
#(
  parameter int N_STAGES = 4,
  parameter int TIMEOUT  = 200000,
  parameter int PERF_W   = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  output logic [N_STAGES-1:0]          stage_start,
  input  logic [N_STAGES-1:0]          stage_done,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [$clog2(N_STAGES):0]    err_stage,
  output logic [$clog2(N_STAGES):0]    cur_stage,
  output logic [N_STAGES*PERF_W-1:0]   perf_cycles
);

  localparam int IDX_W = stage_idx_w(N_STAGES);
  localparam int WD_W  = $clog2(TIMEOUT) + 1;

  seq_state_e state;
  logic       cur_done;
  logic       is_last;
  logic       wd_timeout;

  // Only the done line of the stage being awaited matters; others are ignored.
  always_comb begin
    cur_done = 1'b0;
    for (int i = 0; i < N_STAGES; i++) begin
      if (cur_stage == IDX_W'(i)) cur_done = stage_done[i];
    end
  end

  assign is_last = (cur_stage == IDX_W'(N_STAGES - 1));

  seq_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (WD_W)
  ) u_watchdog (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (state == LAUNCH),
    .enable     (state == WAIT),
    .load       (1'b0),
    .load_value ('0),
    .timeout    (wd_timeout)
  );

  // Outputs are registered alongside the state, so each takes effect with its state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      stage_start <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_stage   <= '0;
      cur_stage   <= '0;
    end else begin
      stage_start <= '0;
      done        <= 1'b0;
      case (state)
        IDLE, ERROR: begin
          if (start) begin
            state       <= LAUNCH;
            stage_start <= N_STAGES'(1);
            busy        <= 1'b1;
            error       <= 1'b0;
            err_stage   <= '0;
            cur_stage   <= '0;
          end
        end
        LAUNCH: begin
          state <= WAIT;
        end
        WAIT: begin
          // A done arriving on the timeout cycle still completes the stage.
          if (cur_done) begin
            if (is_last) begin
              state <= FINISH;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state       <= LAUNCH;
              cur_stage   <= cur_stage + IDX_W'(1);
              stage_start <= N_STAGES'(1) << (cur_stage + IDX_W'(1));
            end
          end else if (wd_timeout) begin
            state     <= ERROR;
            error     <= 1'b1;
            err_stage <= cur_stage;
            busy      <= 1'b0;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CNN_SEQ_PERF_EN
  logic [PERF_W-1:0] perf_cnt [N_STAGES];
  logic              frame_go;
  logic              counting;

  assign frame_go = start && (state == IDLE || state == ERROR);
  assign counting = (state == LAUNCH) || (state == WAIT);

  // Counts the launch cycle through the accepted-done cycle; holds once the frame ends.
  always_ff @(posedge clk) begin
    if (!reset_n || frame_go) begin
      for (int i = 0; i < N_STAGES; i++) perf_cnt[i] <= '0;
    end else if (counting) begin
      for (int i = 0; i < N_STAGES; i++) begin
        if (cur_stage == IDX_W'(i) && perf_cnt[i] != '1) begin
          perf_cnt[i] <= perf_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    perf_cycles = '0;
    for (int i = 0; i < N_STAGES; i++) begin
      perf_cycles[i*PERF_W +: PERF_W] = perf_cnt[i];
    end
  end
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Bench for cnn_layer_sequencer: stub stages, timeline model, directed and random frames.
module tb_cnn_layer_sequencer;

  localparam int N    = 4;
  localparam int T    = 50;
  localparam int PW   = 32;
  localparam int IW   = $clog2(N) + 1;
  localparam int MAXC = 6000;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  stage_done = '0;
  logic [N-1:0]  stage_start;
  logic          busy, done, error;
  logic [IW-1:0] err_stage, cur_stage;
  logic [N*PW-1:0] perf_cycles;

  cnn_layer_sequencer #(
    .N_STAGES (N),
    .TIMEOUT  (T),
    .PERF_W   (PW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .stage_start (stage_start),
    .stage_done  (stage_done),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .err_stage   (err_stage),
    .cur_stage   (cur_stage),
    .perf_cycles (perf_cycles)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit [N-1:0]    start;
    bit            busy;
    bit            done;
    bit            error;
    int            err_stage;
    int            cur;
    bit [N*PW-1:0] perf;
  } exp_t;

  exp_t       exp_tab [MAXC];
  bit [N-1:0] done_sched [MAXC+300];
  int         lat [N];
  int         next_lat [N];
  int         hold_len = 1;
  int         next_hold = 1;
  int         accept_from = 0;
  int         checks = 0;
  int         errors = 0;

  int         st_cyc [$];
  bit [N-1:0] st_vec [$];
  int         dn_cyc [$];

  task automatic check_val(input string name, input int n,
                           input logic [N*PW-1:0] act, input logic [N*PW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, n, act, expv);
    end
  endtask

  // Timeline model: stage k runs from its launch through launch+latency, then the next begins.
  task automatic plan_frame(input int s);
    int launch_c [N];
    int last_c [N];
    int run [N];
    int c, nst, end_c, err_k, k;
    bit err;
    exp_t e;
    c = s + 1; nst = 0; err = 1'b0; err_k = 0;
    for (int i = 0; i < N; i++) begin
      launch_c[i] = c;
      nst = i + 1;
      if (lat[i] >= 1 && lat[i] <= T) begin
        last_c[i] = c + lat[i];
        c = c + lat[i] + 1;
      end else begin
        last_c[i] = c + T;
        c = c + T + 1;
        err = 1'b1;
        err_k = i;
        break;
      end
    end
    end_c = c;
    for (int i = 0; i < N; i++) run[i] = 0;
    for (int n = s + 1; n < MAXC; n++) begin
      e.start = '0; e.busy = 0; e.done = 0; e.error = 0; e.err_stage = 0; e.cur = 0;
      for (int i = 0; i < N; i++) e.perf[i*PW +: PW] = PW'(run[i]);
      if (n < end_c) begin
        k = 0;
        for (int i = 0; i < nst; i++) if (n >= launch_c[i] && n <= last_c[i]) k = i;
        e.busy  = 1'b1;
        e.cur   = k;
        e.start = (n == launch_c[k]) ? (N'(1) << k) : '0;
        run[k]++;
      end else begin
        e.cur       = err ? err_k : N - 1;
        e.error     = err;
        e.err_stage = err ? err_k : 0;
        e.done      = !err && (n == end_c);
      end
`ifndef CNN_SEQ_PERF_EN
      e.perf = '0;
`endif
      exp_tab[n] = e;
    end
    accept_from = err ? end_c : end_c + 1;
  endtask

  task automatic zero_from(input int n);
    for (int m = n; m < MAXC; m++) begin
      exp_tab[m].start = '0; exp_tab[m].busy = 0; exp_tab[m].done = 0;
      exp_tab[m].error = 0; exp_tab[m].err_stage = 0; exp_tab[m].cur = 0;
      exp_tab[m].perf = '0;
    end
  endtask

  // One cycle of drive: stub stages answer observed launches, then start/reset/spurious inputs.
  task automatic apply_stimulus(input bit do_start, input bit do_reset, input int spur);
    int n;
    n = cyc;
    for (int k = 0; k < N; k++) begin
      if (stage_start[k] === 1'b1 && lat[k] >= 1) begin
        for (int h = 0; h < hold_len; h++) begin
          if (n + lat[k] + h < MAXC + 300) done_sched[n + lat[k] + h][k] = 1'b1;
        end
      end
    end
    if (do_reset) begin
      reset_n = 1'b0;
      start = 1'b0;
      stage_done = '0;
      zero_from(n + 1);
      for (int m = n + 1; m < MAXC + 300; m++) done_sched[m] = '0;
      accept_from = n + 1;
    end else begin
      reset_n = 1'b1;
      start = do_start;
      stage_done = done_sched[n];
      if (spur >= 0) stage_done[spur] = 1'b1;
      if (do_start && n >= accept_from) begin
        lat = next_lat;
        hold_len = next_hold;
        plan_frame(n);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input int n);
    exp_t e;
    e = exp_tab[n];
    check_val("stage_start", n, stage_start, e.start);
    check_val("busy", n, busy, e.busy);
    check_val("done", n, done, e.done);
    check_val("error", n, error, e.error);
    check_val("err_stage", n, err_stage, e.err_stage);
    check_val("cur_stage", n, cur_stage, e.cur);
    check_val("perf_cycles", n, perf_cycles, e.perf);
  endtask

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC) check_output(cyc);
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      if ((|stage_start) === 1'b1) begin
        st_cyc.push_back(cyc);
        st_vec.push_back(stage_start);
      end
      if (done === 1'b1) dn_cyc.push_back(cyc);
    end
  end

  task automatic clear_log();
    st_cyc.delete();
    st_vec.delete();
    dn_cyc.delete();
  endtask

  task automatic run_to(input int target);
    while (cyc < target) apply_stimulus(1'b0, 1'b0, -1);
  endtask

  // Latencies 5/3/4/2: launches at offsets 1,7,11,16 and done at 19 from the start cycle.
  task automatic check_frame(input string tag, input int s, input int base_idx);
    int exp_off [4] = '{1, 7, 11, 16};
    for (int i = 0; i < 4; i++) begin
      if (base_idx + i < st_cyc.size()) begin
        check_val({tag, "_start_cycle"}, s, st_cyc[base_idx + i] - s, exp_off[i]);
        check_val({tag, "_start_vec"}, s, st_vec[base_idx + i], 1 << i);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL sim_timeout: got no end, expected finish before time limit");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    int s, s2, n_st3, j;
    next_lat = '{5, 3, 4, 2};
    next_hold = 1;
    @(posedge clk);
    #1;
    apply_stimulus(1'b0, 1'b1, -1);
    apply_stimulus(1'b0, 1'b1, -1);
    apply_stimulus(1'b0, 1'b0, -1);
    check_val("reset_busy", cyc, busy, 0);
    check_val("reset_error", cyc, error, 0);
    check_val("reset_cur_stage", cyc, cur_stage, 0);

    // Normal frame, a spurious stage_done[2] in stage 0, an extra start 7 cycles in.
    clear_log();
    s = cyc;
    apply_stimulus(1'b1, 1'b0, -1);
    while (cyc < s + 24) apply_stimulus(cyc - s == 7, 1'b0, (cyc - s == 3) ? 2 : -1);
    check_val("t1_nstarts", s, st_cyc.size(), 4);
    check_frame("t1", s, 0);
    check_val("t1_ndone", s, dn_cyc.size(), 1);
    if (dn_cyc.size() > 0) check_val("t1_done_cycle", s, dn_cyc[0] - s, 19);
`ifdef CNN_SEQ_PERF_EN
    check_val("t1_perf", cyc, perf_cycles, {32'd3, 32'd5, 32'd4, 32'd6});
`else
    check_val("t1_perf", cyc, perf_cycles, 0);
`endif

    // Stage 1 hangs: error on the cycle after its 50th wait cycle.
    next_lat = '{5, 0, 4, 2};
    clear_log();
    s = cyc;
    apply_stimulus(1'b1, 1'b0, -1);
    run_to(s + 57);
    check_val("t2_error_before", cyc, error, 0);
    apply_stimulus(1'b0, 1'b0, -1);
    check_val("t2_error", cyc, error, 1);
    check_val("t2_err_stage", cyc, err_stage, 1);
    check_val("t2_busy", cyc, busy, 0);
    run_to(s + 66);
    check_val("t2_ndone", s, dn_cyc.size(), 0);
    check_val("t2_nstarts", s, st_cyc.size(), 2);
`ifdef CNN_SEQ_PERF_EN
    check_val("t2_perf", cyc, perf_cycles, {32'd0, 32'd0, 32'd51, 32'd6});
`endif
    next_lat = '{5, 3, 4, 2};
    clear_log();
    s = cyc;
    apply_stimulus(1'b1, 1'b0, -1);
    run_to(s + 24);
    check_val("t2r_error", cyc, error, 0);
    check_frame("t2r", s, 0);
    check_val("t2r_ndone", s, dn_cyc.size(), 1);
    if (dn_cyc.size() > 0) check_val("t2r_done_cycle", s, dn_cyc[0] - s, 19);

    // Reset pulse during WAIT(2).
    clear_log();
    s = cyc;
    apply_stimulus(1'b1, 1'b0, -1);
    run_to(s + 12);
    apply_stimulus(1'b0, 1'b1, -1);
    check_val("t3_busy", cyc, busy, 0);
    check_val("t3_stage_start", cyc, stage_start, 0);
    check_val("t3_cur_stage", cyc, cur_stage, 0);
    check_val("t3_perf", cyc, perf_cycles, 0);
    run_to(s + 40);
    n_st3 = 0;
    foreach (st_vec[i]) if (st_vec[i][3]) n_st3++;
    check_val("t3_no_stage3", s, n_st3, 0);
    check_val("t3_ndone", s, dn_cyc.size(), 0);
    clear_log();
    s = cyc;
    apply_stimulus(1'b1, 1'b0, -1);
    run_to(s + 24);
    check_frame("t3r", s, 0);
    if (dn_cyc.size() > 0) check_val("t3r_done_cycle", s, dn_cyc[0] - s, 19);

    // Back-to-back: start held through the done cycle into the following idle cycle.
    clear_log();
    s = cyc;
    apply_stimulus(1'b1, 1'b0, -1);
    run_to(s + 19);
    apply_stimulus(1'b1, 1'b0, -1);
    s2 = cyc;
    apply_stimulus(1'b1, 1'b0, -1);
    run_to(s2 + 24);
    check_val("t4_nstarts", s, st_cyc.size(), 8);
    check_frame("t4a", s, 0);
    check_frame("t4b", s2, 4);
    check_val("t4_ndone", s, dn_cyc.size(), 2);
    if (dn_cyc.size() > 1) check_val("t4_done2_cycle", s, dn_cyc[1] - s, 39);

    // Stage done lands on the timeout cycle: completion wins.
    next_lat = '{1, 50, 1, 1};
    clear_log();
    s = cyc;
    apply_stimulus(1'b1, 1'b0, -1);
    run_to(s + 62);
    check_val("t5_ndone", s, dn_cyc.size(), 1);
    if (dn_cyc.size() > 0) check_val("t5_done_cycle", s, dn_cyc[0] - s, 58);
    check_val("t5_error", cyc, error, 0);

    // Random frames against the timeline model.
    while (cyc < MAXC - 400) begin
      for (int k = 0; k < N; k++) next_lat[k] = $urandom_range(1, 8);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: next_lat[$urandom_range(0, N-1)] = 0;
          1: next_lat[$urandom_range(0, N-1)] = T - 1;
          2: next_lat[$urandom_range(0, N-1)] = T;
          default: next_lat[$urandom_range(0, N-1)] = T + 1;
        endcase
      end
      next_hold = $urandom_range(1, 2);
      repeat ($urandom_range(0, 3)) apply_stimulus(1'b0, 1'b0, -1);
      apply_stimulus(1'b1, 1'b0, -1);
      while (cyc < accept_from) begin
        if ($urandom_range(0, 149) == 0) begin
          apply_stimulus(1'b0, 1'b1, -1);
        end else begin
          j = -1;
          if ($urandom_range(0, 5) == 0) j = (exp_tab[cyc].cur + $urandom_range(1, N-1)) % N;
          apply_stimulus($urandom_range(0, 9) == 0, 1'b0, j);
        end
      end
    end
    repeat (5) apply_stimulus(1'b0, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
